// File: rtl/sensor_ultrasonico.sv
// HC-SR04 style ultrasonic ranger: periodic trigger, echo pulse-width to centimetres,
// with timeout reporting (distancia=511, timeout=1) when no complete echo arrives.
module sensor_ultrasonico #(
  parameter int TRIG_CICLOS    = 500,
  parameter int CICLOS_POR_CM  = 2900,
  parameter int PERIODO_CICLOS = 3000000,
  parameter int TIMEOUT_CICLOS = 1500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       echo,
  output logic       trigger,
  output logic [8:0] distancia,
  output logic       valido,
  output logic       timeout
);

  // estado     | significado
  // ESPERA     | idle until the period counter completes (or first cycle after reset)
  // DISPARO    | trigger high for TRIG_CICLOS cycles
  // ESPERA_ECO | waiting for a clean echo rising edge, timeout running
  // MIDIENDO   | counting echo-high cycles, timeout still running
  typedef enum logic [1:0] {ESPERA, DISPARO, ESPERA_ECO, MIDIENDO} estado_t;

  localparam int W_PER  = (PERIODO_CICLOS > 1) ? $clog2(PERIODO_CICLOS) : 1;
  localparam int W_TRIG = (TRIG_CICLOS    > 1) ? $clog2(TRIG_CICLOS)    : 1;
  localparam int W_TO   = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam int W_SUB  = (CICLOS_POR_CM  > 1) ? $clog2(CICLOS_POR_CM)  : 1;

  estado_t r_estado, w_estado_sig;

  logic              r_echo_m, r_echo_s, r_echo_d;
  logic              r_arrancado;
  logic [W_PER-1:0]  r_cnt_per;
  logic [W_TRIG-1:0] r_cnt_trig;
  logic [W_TO-1:0]   r_cnt_to;
  logic [W_SUB-1:0]  r_cnt_sub;
  logic [8:0]        r_cm;
  logic              r_trigger, r_valido, r_timeout;
  logic [8:0]        r_distancia;

  logic w_subida, w_bajada, w_fin_per, w_fin_trig, w_fin_to;
  logic w_fin_eco, w_fin_timeout, w_entra_disparo, w_cuenta;

  assign w_subida   = r_echo_s & ~r_echo_d;
  assign w_bajada   = ~r_echo_s & r_echo_d;
  assign w_fin_per  = (r_cnt_per  == W_PER'(PERIODO_CICLOS - 1));
  assign w_fin_trig = (r_cnt_trig == W_TRIG'(TRIG_CICLOS - 1));
  assign w_fin_to   = (r_cnt_to   == W_TO'(TIMEOUT_CICLOS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_estado <= ESPERA;
    else          r_estado <= w_estado_sig;
  end

  // r_arrancado forces the very first trigger right after reset release
  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      ESPERA:     if (!r_arrancado || w_fin_per) w_estado_sig = DISPARO;
      DISPARO:    if (w_fin_trig) w_estado_sig = ESPERA_ECO;
      ESPERA_ECO: if (w_fin_to) w_estado_sig = ESPERA;
                  else if (w_subida) w_estado_sig = MIDIENDO;
      MIDIENDO:   if (w_bajada || w_fin_to) w_estado_sig = ESPERA;
      default:    w_estado_sig = ESPERA;
    endcase
  end

  // A falling edge beats a simultaneous timeout
  always_comb begin
    w_fin_eco       = 1'b0;
    w_fin_timeout   = 1'b0;
    w_cuenta        = 1'b0;
    w_entra_disparo = (w_estado_sig == DISPARO) && (r_estado != DISPARO);
    case (r_estado)
      ESPERA_ECO: begin
        w_fin_timeout = w_fin_to;
        w_cuenta      = w_subida;
      end
      MIDIENDO: begin
        w_fin_eco     = w_bajada;
        w_fin_timeout = w_fin_to && !w_bajada;
        w_cuenta      = r_echo_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_echo_m    <= 1'b0;
      r_echo_s    <= 1'b0;
      r_echo_d    <= 1'b0;
      r_arrancado <= 1'b0;
      r_cnt_per   <= '0;
      r_cnt_trig  <= '0;
      r_cnt_to    <= '0;
      r_cnt_sub   <= '0;
      r_cm        <= '0;
      r_trigger   <= 1'b0;
      r_valido    <= 1'b0;
      r_timeout   <= 1'b0;
      r_distancia <= '0;
    end else begin
      r_echo_m <= echo;
      r_echo_s <= r_echo_m;
      r_echo_d <= r_echo_s;

      if (w_entra_disparo) r_arrancado <= 1'b1;

      if (w_entra_disparo || w_fin_per) r_cnt_per <= '0;
      else                              r_cnt_per <= r_cnt_per + W_PER'(1);

      if (r_estado == DISPARO && !w_fin_trig) r_cnt_trig <= r_cnt_trig + W_TRIG'(1);
      else                                    r_cnt_trig <= '0;

      if (r_estado == ESPERA_ECO || r_estado == MIDIENDO) r_cnt_to <= r_cnt_to + W_TO'(1);
      else                                                r_cnt_to <= '0;

      if (w_entra_disparo) begin
        r_cnt_sub <= '0;
        r_cm      <= '0;
      end else if (w_cuenta) begin
        if (r_cnt_sub == W_SUB'(CICLOS_POR_CM - 1)) begin
          r_cnt_sub <= '0;
          if (r_cm != 9'd511) r_cm <= r_cm + 9'd1;
        end else begin
          r_cnt_sub <= r_cnt_sub + W_SUB'(1);
        end
      end

      r_trigger <= (w_estado_sig == DISPARO);
      r_valido  <= w_fin_eco || w_fin_timeout;
      if (w_fin_eco) begin
        r_distancia <= r_cm;
        r_timeout   <= 1'b0;
      end else if (w_fin_timeout) begin
        r_distancia <= 9'd511;
        r_timeout   <= 1'b1;
      end
    end
  end

  assign trigger   = r_trigger;
  assign distancia = r_distancia;
  assign valido    = r_valido;
  assign timeout   = r_timeout;

endmodule

// File: doc/sensor_ultrasonico.md
SENSOR_ULTRASONICO -- requirements
Module: sensor_ultrasonico

Interface
REQ-001 SHALL have parameter TRIG_CICLOS, default 500: trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-002 SHALL have parameter CICLOS_POR_CM, default 2900: echo-high cycles per centimetre (58 us at 50 MHz).
REQ-003 SHALL have parameter PERIODO_CICLOS, default 3000000: cycles between consecutive trigger starts (60 ms).
REQ-004 SHALL have parameter TIMEOUT_CICLOS, default 1500000: maximum cycles from trigger end to echo fall.
REQ-005 SHALL have port clk, input, 1: single system clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port echo, input, 1: raw sensor echo, asynchronous to clk.
REQ-008 SHALL have port trigger, output, 1: sensor trigger, registered.
REQ-009 SHALL have port distancia, output, 9: last measured distance in cm, registered, feeds the stage controller.
REQ-010 SHALL have port valido, output, 1: one-cycle strobe when distancia updates.
REQ-011 SHALL have port timeout, output, 1: high while the last measurement timed out.

Function
REQ-012 SHALL synchronise echo through two flops (echo_s); all echo decisions SHALL use echo_s and the previous sample echo_d.
REQ-013 SHALL implement states ESPERA, DISPARO, ESPERA_ECO, MIDIENDO.
REQ-014 SHALL run a free period counter 0..PERIODO_CICLOS-1 that wraps to 0; it SHALL reset to 0 on each DISPARO entry.
REQ-015 ESPERA -> DISPARO when the period counter equals PERIODO_CICLOS-1. The first DISPARO SHALL be entered on the first clock edge after reset_n deasserts.
REQ-016 DISPARO SHALL drive trigger=1 for exactly TRIG_CICLOS cycles, then go to ESPERA_ECO with trigger=0.
REQ-017 ESPERA_ECO -> MIDIENDO only on a rising edge (echo_d=0, echo_s=1). An echo already high on entry SHALL be ignored until it has gone low.
REQ-018 In MIDIENDO, each cycle with echo_s=1 SHALL increment a sub-counter.
- When the sub-counter reaches CICLOS_POR_CM-1, it SHALL wrap to 0 and the cm counter SHALL increment.
- The cm counter SHALL saturate at 511.
REQ-019 On a falling edge in MIDIENDO:
- distancia SHALL take the cm counter (floor of cycles/CICLOS_POR_CM) on the next edge.
- timeout SHALL become 0 and valido SHALL pulse 1 for one cycle.
- The FSM SHALL return to ESPERA.
REQ-020 A timeout counter SHALL start at 0 on ESPERA_ECO entry and count through ESPERA_ECO and MIDIENDO. On reaching TIMEOUT_CICLOS-1 the block SHALL:
- set distancia=511, timeout=1, and pulse valido;
- go to ESPERA.
REQ-021 If timeout and a falling edge occur in the same cycle, the falling-edge result (REQ-019) SHALL win.
REQ-022 Echo activity in ESPERA or DISPARO SHALL be ignored and SHALL NOT alter distancia.
REQ-023 distancia and timeout SHALL hold their values between updates; valido SHALL be 0 except during the update strobe.
REQ-024 The cm and sub-counters SHALL clear on every DISPARO entry.
REQ-025 Parameters SHALL satisfy TRIG_CICLOS + TIMEOUT_CICLOS < PERIODO_CICLOS; the block SHALL NOT need to behave correctly otherwise.

Reset
REQ-026 While reset_n=0: trigger=0, distancia=0, valido=0, timeout=0, state=ESPERA, and all counters and synchroniser flops =0, regardless of clk.
REQ-027 Reset asserted mid-measurement SHALL abort it without a valido pulse. A new cycle SHALL start per REQ-015.

Verification (TRIG_CICLOS=4, CICLOS_POR_CM=10, PERIODO_CICLOS=1000, TIMEOUT_CICLOS=400)
REQ-028 Release reset -> trigger high exactly 4 cycles starting first edge after release; next trigger rise 1000 cycles after first.
REQ-029 echo high 85 cycles, 20 cycles after trigger fall -> one valido pulse, distancia=8, timeout=0.
REQ-030 echo never rises -> 400 cycles after trigger fall: valido pulse, distancia=511, timeout=1; next valid echo of 30 cycles -> distancia=3, timeout=0.
REQ-031 echo high 9 cycles -> distancia=0, valido pulse; echo glitch during trigger or ESPERA -> no valido, distancia unchanged.
REQ-032 echo held high from before trigger through whole window -> no rising edge seen, timeout result (511, timeout=1).
REQ-033 reset_n pulsed low while echo high in MIDIENDO -> outputs immediately at reset values, no valido, normal trigger after release.
